// File: rtl/dl_sequencer.sv
// rtl/dl_sequencer.sv - ioctl download router: ROM req/ack, variant byte, DIP bank, core reset sequencing
//
// Ports:
//   clk_sys, reset_n             clock, async active-low reset
//   ioctl_download/wr/index/
//   ioctl_addr/dout              download stream from hps_io
//   ioctl_wait                   stall to hps_io while a ROM write is pending
//   rom_addr/rom_data/rom_req    ROM write to the core, held until rom_ack
//   rom_ack                      core accepted the ROM write
//   mod                          variant select byte
//   dip                          DIP bank, byte k at [8k+7:8k]
//   core_reset                   core reset request, active high
//   overrun                      sticky: write arrived while a ROM write was pending
//   rom_sum                      (DL_CHECKSUM_EN only) mod-256 sum of acked ROM bytes
//
// Optional feature macro: DL_CHECKSUM_EN adds the rom_sum output.
module dl_sequencer #(
  parameter int          ADDR_W    = 16,
  parameter int          DIP_BYTES = 8,
  parameter int          HOLDOFF   = 64,
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [7:0]  MOD_INDEX = 8'd1,
  parameter logic [7:0]  DIP_INDEX = 8'd254
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   rom_req,
  input  logic                   rom_ack,
  output logic [7:0]             mod,
  output logic [8*DIP_BYTES-1:0] dip,
  output logic                   core_reset,
  output logic                   overrun
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]             rom_sum
`endif
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROM_PEND = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dl_q;
  logic             rom_dl_q;
  // Download ended while a ROM write was still outstanding: go to HOLD on ack.
  logic             end_pend;

  logic rom_dl;
  logic rom_fall;
  logic dl_rise;
  logic addr_ok;
  logic rom_hit;

  always_comb begin
    rom_dl   = ioctl_download && (ioctl_index == ROM_INDEX);
    rom_fall = rom_dl_q && !rom_dl;
    dl_rise  = ioctl_download && !dl_q;
    addr_ok  = ((ioctl_addr >> ADDR_W) == 25'd0);
    rom_hit  = ioctl_wr && (ioctl_index == ROM_INDEX) && addr_ok;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HOLD;
      cnt        <= CNT_W'(HOLDOFF);
      core_reset <= 1'b1;
      rom_req    <= 1'b0;
      ioctl_wait <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      end_pend   <= 1'b0;
      dl_q       <= 1'b0;
      rom_dl_q   <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      rom_dl_q <= rom_dl;
      // Any active ROM download holds the core in reset; the HOLD countdown
      // below only releases it on paths where rom_dl is low.
      if (rom_dl) core_reset <= 1'b1;

      case (state)
        IDLE, HOLD: begin
          if (rom_hit) begin
            rom_addr   <= ioctl_addr[ADDR_W-1:0];
            rom_data   <= ioctl_dout;
            rom_req    <= 1'b1;
            ioctl_wait <= 1'b1;
            state      <= ROM_PEND;
            // A write landing in a HOLD with no download active must not
            // strand the core in reset, so it also returns to HOLD on ack.
            end_pend   <= rom_fall || (state == HOLD && !rom_dl);
          end else if (rom_fall) begin
            state <= HOLD;
            cnt   <= CNT_W'(HOLDOFF);
          end else if (state == HOLD) begin
            if (rom_dl) begin
              state <= IDLE;
            end else if (cnt == CNT_W'(1)) begin
              core_reset <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ROM_PEND: begin
          if (rom_ack) begin
            rom_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            end_pend   <= 1'b0;
            if (end_pend || rom_fall) begin
              state <= HOLD;
              cnt   <= CNT_W'(HOLDOFF);
            end else begin
              state <= IDLE;
            end
          end else if (rom_fall) begin
            end_pend <= 1'b1;
          end else if (rom_dl) begin
            end_pend <= 1'b0;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= CNT_W'(HOLDOFF);
        end
      endcase
    end
  end

  // Variant and DIP bytes are only accepted while no ROM write is pending.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod <= '0;
      dip <= '0;
    end else if (ioctl_wr && state != ROM_PEND) begin
      if (ioctl_index == MOD_INDEX) mod <= ioctl_dout;
      if (ioctl_index == DIP_INDEX) begin
        for (int k = 0; k < DIP_BYTES; k++) begin
          if (ioctl_addr == 25'(k)) dip[8*k +: 8] <= ioctl_dout;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else begin
      if (dl_rise) overrun <= 1'b0;
      if (ioctl_wr && state == ROM_PEND) overrun <= 1'b1;
    end
  end

`ifdef DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_sum <= '0;
    end else if (rom_dl && !rom_dl_q) begin
      rom_sum <= '0;
    end else if (state == ROM_PEND && rom_ack) begin
      rom_sum <= rom_sum + rom_data;
    end
  end
`endif

endmodule

// File: tb/tb_dl_sequencer.sv
// tb/tb_dl_sequencer.sv - directed self-checking bench for dl_sequencer
module tb_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  mod;
  logic [63:0] dip;
  logic        core_reset;
  logic        overrun;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  rom_sum;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk_sys = ~clk_sys;

  dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_req        (rom_req),
    .rom_ack        (rom_ack),
    .mod            (mod),
    .dip            (dip),
    .core_reset     (core_reset),
    .overrun        (overrun)
`ifdef DL_CHECKSUM_EN
    ,
    .rom_sum        (rom_sum)
`endif
  );

  // Called at a negedge; returns at the following negedge with the write sampled.
  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    ioctl_wr    = 1'b0;
  endtask

  task automatic ack_once();
    rom_ack = 1'b1;
    @(negedge clk_sys);
    rom_ack = 1'b0;
  endtask

  // Counts clock edges until core_reset drops (bounded).
  task automatic count_hold(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 300) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = '0; rom_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    vecs++; if (ioctl_wait !== 1'b0) begin errs++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
    vecs++; if (rom_req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b want 0", rom_req); end
    vecs++; if (core_reset !== 1'b1) begin errs++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    vecs++; if (dip !== 64'd0 || mod !== 8'd0) begin errs++; $display("FAIL reset_dip_mod: got %h/%h want 0/0", dip, mod); end
    vecs++; if (overrun !== 1'b0 || rom_addr !== 16'd0 || rom_data !== 8'd0) begin errs++; $display("FAIL reset_misc: got ovr=%b addr=%h data=%h want 0", overrun, rom_addr, rom_data); end
    reset_n = 1'b1;
    count_hold(n);
    vecs++; if (n !== 64) begin errs++; $display("FAIL reset_holdoff: got %0d cycles want 64", n); end
  endtask

  task automatic test_rom_write();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    vecs++; if (core_reset !== 1'b1) begin errs++; $display("FAIL rom_dl_core_reset: got %b want 1", core_reset); end
    wr_byte(8'd0, 25'h0123, 8'hA5);
    vecs++; if (rom_req !== 1'b1 || ioctl_wait !== 1'b1) begin errs++; $display("FAIL rom_req_wait: got req=%b wait=%b want 1/1", rom_req, ioctl_wait); end
    vecs++; if (rom_addr !== 16'h0123 || rom_data !== 8'hA5) begin errs++; $display("FAIL rom_latch: got %h/%h want 0123/a5", rom_addr, rom_data); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      vecs++; if (ioctl_wait !== 1'b1 || rom_req !== 1'b1) begin errs++; $display("FAIL rom_wait_held: cycle %0d got wait=%b req=%b want 1/1", i, ioctl_wait, rom_req); end
    end
    ack_once();
    vecs++; if (rom_req !== 1'b0 || ioctl_wait !== 1'b0) begin errs++; $display("FAIL rom_release: got req=%b wait=%b want 0/0", rom_req, ioctl_wait); end
    ioctl_download = 1'b0;
    count_hold(n);
    vecs++; if (n !== 65) begin errs++; $display("FAIL rom_end_holdoff: got %0d cycles want 65", n); end
  endtask

  task automatic test_dip_mod();
    ioctl_index = 8'd254; ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 8; i++) wr_byte(8'd254, 25'(i), 8'(8'h11 * (i + 1)));
    wr_byte(8'd254, 25'd8, 8'hFF);
    @(negedge clk_sys);
    vecs++; if (dip !== 64'h8877665544332211) begin errs++; $display("FAIL dip_bank: got %h want 8877665544332211", dip); end
    vecs++; if (core_reset !== 1'b0) begin errs++; $display("FAIL dip_core_reset: got %b want 0", core_reset); end
    wr_byte(8'd1, 25'd0, 8'h02);
    vecs++; if (mod !== 8'h02) begin errs++; $display("FAIL mod_byte: got %h want 02", mod); end
    wr_byte(8'd1, 25'd7, 8'h05);
    vecs++; if (mod !== 8'h05) begin errs++; $display("FAIL mod_last_wins: got %h want 05", mod); end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    vecs++; if (core_reset !== 1'b0 || rom_req !== 1'b0) begin errs++; $display("FAIL dip_no_side: got rst=%b req=%b want 0/0", core_reset, rom_req); end
  endtask

  task automatic test_overrun();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(8'd0, 25'd5, 8'h33);
    wr_byte(8'd0, 25'd6, 8'h44);
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_set: got %b want 1", overrun); end
    vecs++; if (rom_addr !== 16'd5 || rom_data !== 8'h33) begin errs++; $display("FAIL overrun_dropped: got %h/%h want 0005/33", rom_addr, rom_data); end
    ack_once();
    @(negedge clk_sys);
    vecs++; if (rom_req !== 1'b0) begin errs++; $display("FAIL overrun_no_fwd: got req=%b want 0", rom_req); end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    ioctl_download = 1'b0;
    count_hold(n);
    vecs++; if (n !== 65) begin errs++; $display("FAIL overrun_holdoff: got %0d cycles want 65", n); end
  endtask

  task automatic test_deferred();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(8'd0, 25'h0200, 8'h5A);
    ioctl_download = 1'b0;
    repeat (9) @(negedge clk_sys);
    vecs++; if (core_reset !== 1'b1 || rom_req !== 1'b1) begin errs++; $display("FAIL defer_pending: got rst=%b req=%b want 1/1", core_reset, rom_req); end
    ack_once();
    count_hold(n);
    vecs++; if (n !== 64) begin errs++; $display("FAIL defer_holdoff: got %0d cycles want 64", n); end
  endtask

  task automatic test_out_of_range();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(8'd0, 25'h10000, 8'h77);
    vecs++; if (rom_req !== 1'b0 || ioctl_wait !== 1'b0) begin errs++; $display("FAIL oor_no_req: got req=%b wait=%b want 0/0", rom_req, ioctl_wait); end
    vecs++; if (rom_addr !== 16'h0200 || rom_data !== 8'h5A) begin errs++; $display("FAIL oor_no_latch: got %h/%h want 0200/5a", rom_addr, rom_data); end
    ioctl_download = 1'b0;
    count_hold(n);
    vecs++; if (n !== 65) begin errs++; $display("FAIL oor_holdoff: got %0d cycles want 65", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(8'd0, 25'd1, 8'hF0);
    ack_once();
    vecs++; if (rom_req !== 1'b0) begin errs++; $display("FAIL b2b_release: got req=%b want 0", rom_req); end
    wr_byte(8'd0, 25'd2, 8'h20);
    vecs++; if (rom_req !== 1'b1 || rom_data !== 8'h20 || rom_addr !== 16'd2) begin errs++; $display("FAIL b2b_second: got req=%b %h/%h want 1 0002/20", rom_req, rom_addr, rom_data); end
    ack_once();
    wr_byte(8'd0, 25'd3, 8'h01);
    ack_once();
    vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
`ifdef DL_CHECKSUM_EN
    vecs++; if (rom_sum !== 8'h11) begin errs++; $display("FAIL rom_sum: got %h want 11", rom_sum); end
`endif
    ioctl_download = 1'b0;
    count_hold(n);
    vecs++; if (n !== 65) begin errs++; $display("FAIL b2b_holdoff: got %0d cycles want 65", n); end
  endtask

  task automatic test_async_reset();
    int n;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    @(negedge clk_sys);
    wr_byte(8'd0, 25'h0040, 8'h99);
    #2 reset_n = 1'b0;
    #1;
    vecs++; if (rom_req !== 1'b0 || ioctl_wait !== 1'b0) begin errs++; $display("FAIL async_drop: got req=%b wait=%b want 0/0", rom_req, ioctl_wait); end
    vecs++; if (mod !== 8'd0 || dip !== 64'd0 || rom_addr !== 16'd0) begin errs++; $display("FAIL async_clear: got mod=%h dip=%h addr=%h want 0", mod, dip, rom_addr); end
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    count_hold(n);
    vecs++; if (n !== 64) begin errs++; $display("FAIL async_holdoff: got %0d cycles want 64", n); end
    @(negedge clk_sys);
    vecs++; if (rom_req !== 1'b0) begin errs++; $display("FAIL async_lost: got req=%b want 0", rom_req); end
  endtask

  initial begin
    test_reset();
    test_rom_write();
    test_dip_mod();
    test_overrun();
    test_deferred();
    test_out_of_range();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
